// File: rtl/display_timings_pkg.sv
// Shared timing description types, common video mode presets and helpers
// for the parametrised display timing generator.
package display_timings_pkg;

  typedef struct packed {
    int unsigned res;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  localparam int MAX_DELAY = 7;

  localparam mode_t TIMING_640x480_60 = '{
    h: '{res: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0},
    v: '{res: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0}
  };

  localparam mode_t TIMING_800x600_60 = '{
    h: '{res: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1},
    v: '{res: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1}
  };

  localparam mode_t TIMING_1280x720_60 = '{
    h: '{res: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1},
    v: '{res: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1}
  };

  function automatic int unsigned total(input timing_t t);
    return t.res + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/display_timings_param_if.sv
// Video timing bundle driven by the generator (master) into pixel
// generators and the video output stage (slave).
interface display_timings_param_if #(
  parameter int CORDW = 16,
  parameter int FCW   = 16
);
  logic                    hsync;
  logic                    vsync;
  logic                    de;
  logic                    frame;
  logic                    line;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic [FCW-1:0]          frame_cnt;

  modport master (output hsync, vsync, de, frame, line, sx, sy, frame_cnt);
  modport slave  (input  hsync, vsync, de, frame, line, sx, sy, frame_cnt);
endinterface

// File: rtl/display_timings_param_delay_line.sv
// Fixed-depth register chain with asynchronous reset to a given value;
// depth 0 is a plain wire.
module timing_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/display_timings_param.sv
// Parametrised raster timing generator: signed coordinates (negative in
// blanking), programmable sync polarity, frame counter and output delay.
module display_timings_param
  import display_timings_pkg::*;
#(
  parameter int          CORDW  = 16,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter logic        H_POL  = 1'b0,
  parameter logic        V_POL  = 1'b0,
  parameter int          DELAY  = 0,
  parameter int          FCW    = 16
) (
  input  logic                     clk_pix,
  input  logic                     rst_pix_n,
  display_timings_param_if.master  vid
);

  localparam timing_t H_T = '{res: H_RES, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_POL};
  localparam timing_t V_T = '{res: V_RES, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_POL};

  localparam int H_STA_I = int'(H_RES) - int'(total(H_T));
  localparam int V_STA_I = int'(V_RES) - int'(total(V_T));
  localparam int H_END_I = int'(H_RES) - 1;
  localparam int V_END_I = int'(V_RES) - 1;
  localparam int C_MAX   = (1 << (CORDW - 1)) - 1;

  if (DELAY < 0 || DELAY > MAX_DELAY) begin : g_chk_delay
    $error("display_timings_param: DELAY must be in 0..7");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_porch
    $error("display_timings_param: porch and sync widths must be non-zero");
  end
  if (CORDW < 2 || CORDW > 31 ||
      H_STA_I < -C_MAX - 1 || V_STA_I < -C_MAX - 1 ||
      H_END_I > C_MAX || V_END_I > C_MAX) begin : g_chk_cordw
    $error("display_timings_param: CORDW too narrow for the timing range");
  end

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
  localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_END_I);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
  localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_END_I);
  localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(H_STA_I + int'(H_FP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + int'(H_FP + H_SYNC) - 1);
  localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(V_STA_I + int'(V_FP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + int'(V_FP + V_SYNC) - 1);
  localparam logic signed [CORDW-1:0] C_ZERO = '0;
  localparam logic signed [CORDW-1:0] C_ONE  = CORDW'(1);

  typedef struct packed {
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic                    frame;
    logic                    line;
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic [FCW-1:0]          frame_cnt;
  } vid_t;

  localparam vid_t VID_RST = '{
    hsync: ~H_POL, vsync: ~V_POL, de: 1'b0, frame: 1'b0, line: 1'b0,
    sx: H_STA, sy: V_STA, frame_cnt: '0
  };

  logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
  vid_t                    p0_q, p0_d;
  vid_t                    vid_out;
  logic                    x_end, y_end, frame_now;

  always_comb begin
    x_end     = (x_q == H_END);
    y_end     = (y_q == V_END);
    frame_now = (x_q == H_STA) && (y_q == V_STA);

    x_d = x_end ? H_STA : x_q + C_ONE;
    y_d = y_q;
    if (x_end) y_d = y_end ? V_STA : y_q + C_ONE;

    p0_d.hsync     = ((x_q >= HS_BEG) && (x_q <= HS_END)) ? H_POL : ~H_POL;
    p0_d.vsync     = ((y_q >= VS_BEG) && (y_q <= VS_END)) ? V_POL : ~V_POL;
    p0_d.de        = (x_q >= C_ZERO) && (y_q >= C_ZERO);
    p0_d.frame     = frame_now;
    p0_d.line      = (x_q == H_STA);
    p0_d.sx        = x_q;
    p0_d.sy        = y_q;
    p0_d.frame_cnt = frame_now ? p0_q.frame_cnt + FCW'(1) : p0_q.frame_cnt;
  end

  // Stage 0: counters advance while every decode of the current (x,y) is captured.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      x_q  <= H_STA;
      y_q  <= V_STA;
      p0_q <= VID_RST;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      p0_q <= p0_d;
    end
  end

  // Stages 1..DELAY: whole bundle delayed together so outputs stay aligned.
  timing_delay_line #(
    .WIDTH     ($bits(vid_t)),
    .DEPTH     (DELAY),
    .RESET_VAL (VID_RST)
  ) u_delay (
    .clk_i  (clk_pix),
    .rst_ni (rst_pix_n),
    .d_i    (p0_q),
    .q_o    (vid_out)
  );

  assign vid.hsync     = vid_out.hsync;
  assign vid.vsync     = vid_out.vsync;
  assign vid.de        = vid_out.de;
  assign vid.frame     = vid_out.frame;
  assign vid.line      = vid_out.line;
  assign vid.sx        = vid_out.sx;
  assign vid.sy        = vid_out.sy;
  assign vid.frame_cnt = vid_out.frame_cnt;

endmodule

// File: tb/tb_display_timings_param.sv
// Directed bench: default 640x480 mode at DELAY 0 and 3 (inverted syncs),
// plus a tiny mode with a 2-bit frame counter for frame wrap and mid-frame reset.
module tb_display_timings_param;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  int vec = 0;
  int err = 0;
  int k   = 0;
  int bad_def = 0, bad_dly = 0;
  int first_bad_def = -1, first_bad_dly = -1;

  display_timings_param_if #(.CORDW(16), .FCW(16)) v_def ();
  display_timings_param_if #(.CORDW(16), .FCW(16)) v_dly ();
  display_timings_param_if #(.CORDW(8),  .FCW(2))  v_sm  ();

  display_timings_param u_def (
    .clk_pix (clk_pix), .rst_pix_n (rst_a_n), .vid (v_def)
  );

  display_timings_param #(.H_POL(1'b1), .V_POL(1'b1), .DELAY(3)) u_dly (
    .clk_pix (clk_pix), .rst_pix_n (rst_a_n), .vid (v_dly)
  );

  display_timings_param #(
    .CORDW(8), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .FCW(2)
  ) u_sm (
    .clk_pix (clk_pix), .rst_pix_n (rst_b_n), .vid (v_sm)
  );

  typedef struct packed {
    logic hs, vs, de, fr, ln;
    logic signed [15:0] sx, sy;
    logic [15:0] cnt;
  } exp_t;

  // Closed-form expectation for the default 800x525 raster, n clocks after the first edge.
  function automatic exp_t ref_def(input int n, input logic pol);
    exp_t e;
    int x, y;
    e.hs = ~pol; e.vs = ~pol; e.de = 1'b0; e.fr = 1'b0; e.ln = 1'b0;
    e.sx = -16'sd160; e.sy = -16'sd45; e.cnt = '0;
    if (n >= 0) begin
      x = -160 + n % 800;
      y = -45 + (n / 800) % 525;
      e.hs  = (x >= -144 && x <= -49) ? pol : ~pol;
      e.vs  = (y >= -35 && y <= -34) ? pol : ~pol;
      e.de  = (x >= 0 && y >= 0);
      e.fr  = (n % 420000 == 0);
      e.ln  = (n % 800 == 0);
      e.sx  = 16'(x);
      e.sy  = 16'(y);
      e.cnt = 16'(n / 420000 + 1);
    end
    return e;
  endfunction

  function automatic exp_t act_def();
    return {v_def.hsync, v_def.vsync, v_def.de, v_def.frame, v_def.line,
            v_def.sx, v_def.sy, v_def.frame_cnt};
  endfunction

  function automatic exp_t act_dly();
    return {v_dly.hsync, v_dly.vsync, v_dly.de, v_dly.frame, v_dly.line,
            v_dly.sx, v_dly.sy, v_dly.frame_cnt};
  endfunction

  task automatic step();
    @(posedge clk_pix);
    k++;
    @(negedge clk_pix);
    if (act_def() !== ref_def(k - 1, 1'b0)) begin
      bad_def++;
      if (first_bad_def < 0) first_bad_def = k;
    end
    if (act_dly() !== ref_def(k - 4, 1'b1)) begin
      bad_dly++;
      if (first_bad_dly < 0) first_bad_dly = k;
    end
  endtask

  function automatic logic sm_is_reset();
    return (v_sm.sx === -8'sd9) && (v_sm.sy === -8'sd7) && (v_sm.hsync === 1'b1) &&
           (v_sm.vsync === 1'b1) && (v_sm.de === 1'b0) && (v_sm.frame === 1'b0) &&
           (v_sm.line === 1'b0) && (v_sm.frame_cnt === 2'd0);
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk_pix);
    vec++;
    if (act_def() !== ref_def(-1, 1'b0)) begin
      err++; $display("FAIL reset_def: got %h want %h", act_def(), ref_def(-1, 1'b0));
    end
    vec++;
    if (act_dly() !== ref_def(-1, 1'b1)) begin
      err++; $display("FAIL reset_dly: got %h want %h", act_dly(), ref_def(-1, 1'b1));
    end
    vec++;
    if (!sm_is_reset()) begin
      err++; $display("FAIL reset_sm: got sx=%0d sy=%0d cnt=%0d want -9 -7 0",
                      v_sm.sx, v_sm.sy, v_sm.frame_cnt);
    end
  endtask

  task automatic test_first_edge();
    rst_a_n = 1'b1;
    step();
    vec++;
    if (v_def.sx !== -16'sd160 || v_def.sy !== -16'sd45) begin
      err++; $display("FAIL first_xy: got (%0d,%0d) want (-160,-45)", v_def.sx, v_def.sy);
    end
    vec++;
    if ({v_def.frame, v_def.line} !== 2'b11) begin
      err++; $display("FAIL first_strobes: got frame=%b line=%b want 1 1", v_def.frame, v_def.line);
    end
    vec++;
    if (v_def.frame_cnt !== 16'd1) begin
      err++; $display("FAIL first_cnt: got %0d want 1", v_def.frame_cnt);
    end
    vec++;
    if ({v_def.de, v_def.hsync, v_def.vsync} !== 3'b011) begin
      err++; $display("FAIL first_de_sync: got %b want 011", {v_def.de, v_def.hsync, v_def.vsync});
    end
    vec++;
    if (v_dly.frame !== 1'b0 || v_dly.frame_cnt !== 16'd0 || v_dly.hsync !== 1'b0) begin
      err++; $display("FAIL dly_still_reset: got frame=%b cnt=%0d hsync=%b want 0 0 0",
                      v_dly.frame, v_dly.frame_cnt, v_dly.hsync);
    end
  endtask

  task automatic test_vertical();
    int vs_low = 0, vs_min = 9999, vs_max = -9999, de_hi = 0, lines = 0, fr = 0;
    int last_line = 1, bad_gap = 0;
    while (k < 36000) begin
      step();
      if (v_def.vsync === 1'b0) begin
        vs_low++;
        if (int'(v_def.sy) < vs_min) vs_min = int'(v_def.sy);
        if (int'(v_def.sy) > vs_max) vs_max = int'(v_def.sy);
      end
      if (v_def.de === 1'b1) de_hi++;
      if (v_def.frame === 1'b1) fr++;
      if (v_def.line === 1'b1) begin
        lines++;
        if (k - last_line != 800) bad_gap++;
        last_line = k;
      end
    end
    vec++;
    if (vs_low != 1600) begin err++; $display("FAIL vsync_len: got %0d want 1600", vs_low); end
    vec++;
    if (vs_min != -35 || vs_max != -34) begin
      err++; $display("FAIL vsync_rows: got %0d..%0d want -35..-34", vs_min, vs_max);
    end
    vec++;
    if (de_hi != 0) begin err++; $display("FAIL de_blank: got %0d want 0", de_hi); end
    vec++;
    if (lines != 44 || bad_gap != 0) begin
      err++; $display("FAIL line_period: got %0d pulses %0d bad gaps want 44 0", lines, bad_gap);
    end
    vec++;
    if (fr != 0) begin err++; $display("FAIL frame_early: got %0d want 0", fr); end
  endtask

  task automatic test_line();
    int hs_low = 0, hs_min = 9999, hs_max = -9999;
    int de_hi = 0, de_min = 9999, de_max = -9999, lines = 0, row_bad = 0, dly_hs_hi = 0;
    repeat (800) begin
      step();
      if (v_def.hsync === 1'b0) begin
        hs_low++;
        if (int'(v_def.sx) < hs_min) hs_min = int'(v_def.sx);
        if (int'(v_def.sx) > hs_max) hs_max = int'(v_def.sx);
      end
      if (v_def.de === 1'b1) begin
        de_hi++;
        if (int'(v_def.sx) < de_min) de_min = int'(v_def.sx);
        if (int'(v_def.sx) > de_max) de_max = int'(v_def.sx);
      end
      if (v_def.line === 1'b1 && v_def.sx === -16'sd160) lines++;
      if (v_def.sy !== 16'sd0) row_bad++;
      if (v_dly.hsync === 1'b1) dly_hs_hi++;
    end
    vec++;
    if (hs_low != 96 || hs_min != -144 || hs_max != -49) begin
      err++; $display("FAIL hsync_span: got %0d clocks %0d..%0d want 96 -144..-49", hs_low, hs_min, hs_max);
    end
    vec++;
    if (de_hi != 640 || de_min != 0 || de_max != 639) begin
      err++; $display("FAIL de_span: got %0d clocks %0d..%0d want 640 0..639", de_hi, de_min, de_max);
    end
    vec++;
    if (lines != 1 || row_bad != 0) begin
      err++; $display("FAIL row0_line: got %0d pulses %0d off-row want 1 0", lines, row_bad);
    end
    vec++;
    if (dly_hs_hi != 96) begin
      err++; $display("FAIL dly_hsync_pol: got %0d high clocks want 96", dly_hs_hi);
    end
  endtask

  task automatic test_delay_alignment();
    vec++;
    if (bad_def != 0) begin
      err++; $display("FAIL def_stream: got %0d bad cycles (first k=%0d) want 0", bad_def, first_bad_def);
    end
    vec++;
    if (bad_dly != 0) begin
      err++; $display("FAIL dly_stream: got %0d bad cycles (first k=%0d) want 0", bad_dly, first_bad_dly);
    end
  endtask

  task automatic test_frames_small();
    int cnts[$];
    int pos[$];
    int ks = 0, vs_low = 0, wraps = 0, bad_gap = 0;
    logic signed [7:0] prev_sy;
    int want_cnt[5] = '{1, 2, 3, 0, 1};
    rst_b_n = 1'b1;
    prev_sy = -8'sd7;
    repeat (5 * 375) begin
      step();
      ks++;
      if (v_sm.frame === 1'b1) begin
        cnts.push_back(int'(v_sm.frame_cnt));
        pos.push_back(ks);
      end
      if (v_sm.vsync === 1'b0) vs_low++;
      if (prev_sy === 8'sd7 && v_sm.sy === -8'sd7) wraps++;
      prev_sy = v_sm.sy;
    end
    vec++;
    if (cnts.size() != 5) begin
      err++; $display("FAIL sm_frames: got %0d pulses want 5", cnts.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vec++;
        if (cnts[i] != want_cnt[i]) begin
          err++; $display("FAIL sm_cnt_%0d: got %0d want %0d", i, cnts[i], want_cnt[i]);
        end
        if (i > 0 && pos[i] - pos[i-1] != 375) bad_gap++;
      end
      vec++;
      if (bad_gap != 0) begin err++; $display("FAIL sm_frame_gap: got %0d bad gaps want 0", bad_gap); end
    end
    vec++;
    if (vs_low != 250) begin err++; $display("FAIL sm_vsync_len: got %0d want 250", vs_low); end
    vec++;
    if (wraps != 4) begin err++; $display("FAIL sm_sy_wrap: got %0d wraps want 4", wraps); end
  endtask

  task automatic test_reset_mid();
    int tries = 0;
    int held_bad = 0;
    while (!(v_sm.sx === 8'sd5 && v_sm.sy === 8'sd3) && tries < 400) begin
      step();
      tries++;
    end
    vec++;
    if (tries >= 400) begin
      err++; $display("FAIL sm_seek: got no (5,3) within 400 clocks want found");
      return;
    end
    vec++;
    if (v_sm.de !== 1'b1) begin err++; $display("FAIL sm_de_active: got %b want 1", v_sm.de); end
    rst_b_n = 1'b0;
    #1;
    vec++;
    if (!sm_is_reset()) begin
      err++; $display("FAIL sm_async_reset: got sx=%0d sy=%0d cnt=%0d want -9 -7 0",
                      v_sm.sx, v_sm.sy, v_sm.frame_cnt);
    end
    repeat (5) begin
      step();
      if (!sm_is_reset()) held_bad++;
    end
    vec++;
    if (held_bad != 0) begin err++; $display("FAIL sm_reset_hold: got %0d bad clocks want 0", held_bad); end
    rst_b_n = 1'b1;
    step();
    vec++;
    if (v_sm.sx !== -8'sd9 || v_sm.sy !== -8'sd7 || v_sm.frame !== 1'b1 ||
        v_sm.line !== 1'b1 || v_sm.frame_cnt !== 2'd1) begin
      err++; $display("FAIL sm_restart: got (%0d,%0d) f=%b l=%b cnt=%0d want (-9,-7) 1 1 1",
                      v_sm.sx, v_sm.sy, v_sm.frame, v_sm.line, v_sm.frame_cnt);
    end
    step();
    vec++;
    if (v_sm.sx !== -8'sd8 || v_sm.frame !== 1'b0 || v_sm.frame_cnt !== 2'd1) begin
      err++; $display("FAIL sm_restart_next: got sx=%0d f=%b cnt=%0d want -8 0 1",
                      v_sm.sx, v_sm.frame, v_sm.frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_vertical();
    test_line();
    test_frames_small();
    test_reset_mid();
    test_delay_alignment();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/display_timings_param.md
Name: display_timings_param

Overview:
- Parametrised successor to the fixed 640x480 sync generator. Produces hsync/vsync/de, line/frame strobes and signed screen coordinates for any CEA/VESA mode.
- Adds configurable sync polarity, signed coordinates that are negative during blanking, a frame counter, and a programmable output delay line so timing aligns with downstream pixel pipelines.
- Sits between the pixel-clock domain root (clk_pix, rst_pix_n) and the video output / pixel generators.

Parameters:
CORDW, 16, signed coordinate width (bits); must hold -(H_FP+H_SYNC+H_BP) and H_RES-1
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_RES, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_POL, 0, vsync active level
DELAY, 0, extra output register stages, range 0..7
FCW, 16, frame counter width

Ports:
clk_pix  in  1  pixel clock
rst_pix_n  in  1  asynchronous, active-low reset
hsync  out  1  horizontal sync at H_POL level when active
vsync  out  1  vertical sync at V_POL level when active
de  out  1  data enable, high only in the active area
frame  out  1  one-clock pulse at the first pixel of a frame
line  out  1  one-clock pulse at the first pixel of each line
sx  out  CORDW signed  horizontal position
sy  out  CORDW signed  vertical position
frame_cnt  out  FCW  count of frames started since reset, wraps

Behaviour:
- Constants: H_STA = -(H_FP+H_SYNC+H_BP); H_END = H_RES-1; V_STA = -(V_FP+V_SYNC+V_BP); V_END = V_RES-1. Defaults give H_STA = -160 and V_STA = -45.
- Internal counters x and y, signed CORDW. Both reset asynchronously to (H_STA, V_STA).
- Each clock, x increments. At x==H_END, x wraps to H_STA and y increments. At x==H_END and y==V_END, y wraps to V_STA.
- Blanking order from H_STA is front porch, then sync, then back porch.
  - hsync active for x in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1].
  - vsync active for y in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1], for whole lines.
- de = (x>=0) && (y>=0), using signed compares only.
- line = (x==H_STA). frame = (x==H_STA && y==V_STA).
- Stage 0: all decodes, plus x and y, are registered together on the same edge, so every output describes the same (x,y).
- frame_cnt increments in stage 0 on the same edge that registers frame=1. Its value therefore reflects frames started, including the current one.
- DELAY additional identical register stages follow stage 0. Total latency from counter to outputs is 1+DELAY clocks, and all outputs stay mutually aligned.
- Output reset values, applied to every stage:
  - hsync = ~H_POL, vsync = ~V_POL
  - de = 0, frame = 0, line = 0
  - sx = H_STA, sy = V_STA
  - frame_cnt = 0
- After reset release, the first rising edge loads stage 0 with (H_STA, V_STA), frame=1, line=1 and frame_cnt=1. These values appear on the outputs DELAY clocks later.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronous). The counters restart from (H_STA, V_STA) with no partial line.
- Reset deassertion is assumed synchronised to clk_pix upstream.
- Elaboration errors (assertions) fire when:
  - DELAY > 7
  - any porch or sync parameter is 0
  - CORDW is too narrow for H_STA, V_STA, H_END or V_END
- No combinational path from inputs to outputs.

Decomposition:
- Package display_timings_pkg holds:
  - timing_t struct: res, fp, sync, bp, pol for each axis
  - preset constants TIMING_640x480_60, TIMING_800x600_60, TIMING_1280x720_60
  - function total(timing_t), returning res+fp+sync+bp
- One sub-module, timing_delay_line:
  - parametrised WIDTH and DEPTH (0 means pass-through)
  - async active-low reset to a RESET_VAL parameter
  - carries the packed {hsync, vsync, de, frame, line, sx, sy, frame_cnt} bundle

Test Plan:
- Defaults, DELAY=0, release reset → first output edge shows sx=-160, sy=-45, frame=1, line=1, frame_cnt=1; de=0, hsync=1, vsync=1.
- Defaults, count one line → line pulses every 800 clocks; hsync low for exactly 96 clocks with sx from -144 to -49; de high for 640 clocks with sx from 0 to 639.
- Defaults, run 2 frames → frame pulses 420000 clocks apart; vsync low for 1600 clocks over sy -35..-34; de low for all sy<0; sy wraps 479 → -45; frame_cnt reaches 2.
- H_POL=1, V_POL=1, DELAY=3 → sync pulses are inverted; every output equals the DELAY=0 reference run shifted by exactly 3 clocks.
- Assert rst_pix_n at sx=100, sy=200, hold 5 clocks → outputs take reset values immediately; after release the sequence restarts at (-160,-45) with frame_cnt=1.
- FCW=2, run 5 frames → frame_cnt sequence 1,2,3,0,1.
